// File: rtl/desired_drive_pkg.sv
// desired_drive_pkg: shared state type, incline clamp constants and width helper for the desired-current sequencer
package desired_drive_pkg;

    typedef enum logic [2:0] {IDLE, MUL_TS, MUL_CI, MUL_ABC, SLEW} state_t;

    localparam logic signed [12:0] INCL_MIN = -13'sd512;
    localparam logic signed [12:0] INCL_MAX = 13'sd511;
    localparam logic signed [12:0] INCL_OFS = 13'sd256;

    localparam logic [11:0] DEF_TORQUE_MIN = 12'h380;

    // Width of torque*setting*cadence*incline: cad_f adds one bit, incl_lim is 9 bits.
    function automatic int prod_w(input int tq_w, input int set_w, input int cad_w);
        return tq_w + set_w + cad_w + 10;
    endfunction

endpackage

// File: rtl/incline_clamp.sv
// incline_clamp: maps a 13-bit signed incline to a 9-bit unsigned assist multiplier
// Ports: incline (13-bit signed in), incl_lim (9-bit unsigned out, 0..511)
module incline_clamp
    import desired_drive_pkg::*;
(
    input  logic signed [12:0] incline,
    output logic        [8:0]  incl_lim
);

    logic signed [12:0] sat;
    logic signed [12:0] ofs;

    assign sat      = (incline < INCL_MIN) ? INCL_MIN : (incline > INCL_MAX) ? INCL_MAX : incline;
    assign ofs      = sat + INCL_OFS;
    assign incl_lim = (ofs < 13'sd0) ? 9'd0 : (ofs > INCL_MAX) ? 9'd511 : ofs[8:0];

endmodule

// File: rtl/desired_drive_seq.sv
// desired_drive_seq: sequenced desired-motor-current calculator with one shared multiplier and slew limiting
// Ports: clk, rst_n (async active-low); strt starts a run when idle; avg_torque, cadence_vec,
// incline (signed), setting are captured on start; busy is high while running; vld pulses for
// one cycle when target_curr is updated; target_curr holds between updates.
module desired_drive_seq
    import desired_drive_pkg::*;
#(
    parameter int               TQ_W       = 12,
    parameter int               CAD_W      = 5,
    parameter int               SET_W      = 2,
    parameter int               OUT_W      = 12,
    parameter logic [TQ_W-1:0]  TORQUE_MIN = TQ_W'(DEF_TORQUE_MIN),
    parameter int               SHIFT      = 14,
    parameter logic [OUT_W-1:0] SLEW_STEP  = '0
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    strt,
    input  logic [TQ_W-1:0]         avg_torque,
    input  logic [CAD_W-1:0]        cadence_vec,
    input  logic signed [12:0]      incline,
    input  logic [SET_W-1:0]        setting,
    output logic                    busy,
    output logic                    vld,
    output logic [OUT_W-1:0]        target_curr
);

    localparam int PW = prod_w(TQ_W, SET_W, CAD_W);
    localparam int AW = TQ_W + SET_W;
    localparam int BW = CAD_W + 10;

    state_t            state;
    logic [TQ_W-1:0]   tq_r;
    logic [CAD_W-1:0]  cad_r;
    logic [12:0]       incl_r;
    logic [SET_W-1:0]  set_r;
    logic [AW-1:0]     a_r;
    logic [BW-1:0]     b_r;
    logic [PW-1:0]     p_r;

    logic [TQ_W-1:0]   tq_pos;
    logic [CAD_W:0]    cad_f;
    logic [8:0]        incl_lim;
    logic [AW-1:0]     mul_a;
    logic [BW-1:0]     mul_b;
    logic [PW-1:0]     mul_p;
    logic              ovf;
    logic              up;
    logic [OUT_W-1:0]  sat;
    logic [OUT_W-1:0]  diff;
    logic [OUT_W-1:0]  step;
    logic [OUT_W-1:0]  next_curr;

    assign tq_pos = (tq_r > TORQUE_MIN) ? tq_r - TORQUE_MIN : '0;
    // Only the LSB set means the crank is effectively stopped; otherwise bias cadence upward.
    assign cad_f  = (cad_r[CAD_W-1:1] == '0) ? '0 : {1'b1, cad_r};

    incline_clamp u_incline_clamp (
        .incline  (incl_r),
        .incl_lim (incl_lim)
    );

    // One multiplier, operands selected by the current FSM step.
    assign mul_a = (state == MUL_ABC) ? a_r : (state == MUL_CI) ? AW'(cad_f) : AW'(tq_pos);
    assign mul_b = (state == MUL_ABC) ? b_r : (state == MUL_CI) ? BW'(incl_lim) : BW'(set_r);
    assign mul_p = {{BW{1'b0}}, mul_a} * {{AW{1'b0}}, mul_b};

    assign ovf       = |(p_r >> (SHIFT + OUT_W));
    assign sat       = ovf ? '1 : OUT_W'(p_r >> SHIFT);
    // Step toward sat by at most SLEW_STEP using the unsigned distance, so it cannot wrap or overshoot.
    assign up        = sat > target_curr;
    assign diff      = up ? sat - target_curr : target_curr - sat;
    assign step      = (SLEW_STEP == '0 || diff < SLEW_STEP) ? diff : SLEW_STEP;
    assign next_curr = (set_r == '0) ? '0 : up ? target_curr + step : target_curr - step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            vld         <= 1'b0;
            target_curr <= '0;
            tq_r        <= '0;
            cad_r       <= '0;
            incl_r      <= '0;
            set_r       <= '0;
            a_r         <= '0;
            b_r         <= '0;
            p_r         <= '0;
        end else begin
            vld <= 1'b0;
            case (state)
                IDLE: if (strt) begin
                    tq_r   <= avg_torque;
                    cad_r  <= cadence_vec;
                    incl_r <= incline;
                    set_r  <= setting;
                    busy   <= 1'b1;
                    state  <= MUL_TS;
                end
                MUL_TS: begin
                    a_r   <= mul_p[AW-1:0];
                    state <= MUL_CI;
                end
                MUL_CI: begin
                    b_r   <= mul_p[BW-1:0];
                    state <= MUL_ABC;
                end
                MUL_ABC: begin
                    p_r   <= mul_p;
                    state <= SLEW;
                end
                SLEW: begin
                    target_curr <= next_curr;
                    vld         <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
